// File: rtl/ppu_scanout_if.sv
// Scanout-side bundle: row-RAM and palette-RAM read ports, PPU swap control and video pins.
// master = ppu_scanout, slave = RAMs / PPU / HDMI transmitter.
interface ppu_scanout_if;
   logic [8:0]  rowram_rdaddr;
   logic [9:0]  rowram_rddata;
   logic [8:0]  palram_rdaddr;
   logic [63:0] palram_rddata;
   logic        rowram_swap;
   logic [7:0]  next_row;
   logic [7:0]  vid_r;
   logic [7:0]  vid_g;
   logic [7:0]  vid_b;
   logic        vid_hsync;
   logic        vid_vsync;
   logic        vid_de;

   modport master (
      output rowram_rdaddr, palram_rdaddr, rowram_swap, next_row,
      output vid_r, vid_g, vid_b, vid_hsync, vid_vsync, vid_de,
      input  rowram_rddata, palram_rddata
   );

   modport slave (
      input  rowram_rdaddr, palram_rdaddr, rowram_swap, next_row,
      input  vid_r, vid_g, vid_b, vid_hsync, vid_vsync, vid_de,
      output rowram_rddata, palram_rddata
   );
endinterface

// File: rtl/ppu_scanout.sv
// Display end of the PPU row-RAM protocol: 640x480 raster timing, 2x-scaled row-buffer reads,
// palette lookup to 24-bit RGB, and the per-row buffer-swap schedule for the PPU.
module ppu_scanout #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33
) (
   input  logic          clk,
   input  logic          rst,
   ppu_scanout_if.master bus
);

   localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] HLast     = 10'(HTotal - 1);
   localparam logic [9:0] HVis      = 10'(H_VISIBLE);
   localparam logic [9:0] HVisM1    = 10'(H_VISIBLE - 1);
   localparam logic [9:0] HSyncBeg  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HSyncEnd  = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VLast     = 10'(VTotal - 1);
   localparam logic [9:0] VVis      = 10'(V_VISIBLE);
   localparam logic [9:0] VSyncBeg  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VSyncEnd  = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [9:0] VLastSwap = 10'(V_VISIBLE - 3);
   localparam logic [9:0] VPreLast  = 10'(VTotal - 2);

   logic [9:0]  h_q, h_d, v_q, v_d;
   logic [1:0]  de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
   logic        vid_de_q, vid_de_d, vid_hs_q, vid_hs_d, vid_vs_q, vid_vs_d;
   logic        half_q, half_d;
   logic        frame_valid_q, frame_valid_d;
   logic        swap_q, swap_d;
   logic [7:0]  next_row_q, next_row_d;
   logic [23:0] rgb_q, rgb_d;
   logic        de_raw, hs_raw, vs_raw, swap_line;
   logic [23:0] colour;
   logic        unused_alpha;

   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == HLast) begin
         h_d = '0;
         v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end

      de_raw = (h_q < HVis) && (v_q < VVis);
      hs_raw = !((h_q >= HSyncBeg) && (h_q < HSyncEnd));
      vs_raw = !((v_q >= VSyncBeg) && (v_q < VSyncEnd));

      // Registered pulse lands on h == H_VISIBLE, after the last visible read of the line.
      swap_line = (v_q[0] && (v_q <= VLastSwap)) || (v_q == VPreLast);
      swap_d    = (h_q == HVisM1) && swap_line;

      next_row_d = next_row_q;
      if (swap_d) begin
         if (v_q == VPreLast)       next_row_d = 8'd1;
         else if (v_q == VLastSwap) next_row_d = 8'd0;
         else                       next_row_d = 8'((v_q + 10'd3) >> 1);
      end
      frame_valid_d = frame_valid_q | (swap_d && (v_q == VPreLast));

      de_pipe_d = {de_pipe_q[0], de_raw};
      hs_pipe_d = {hs_pipe_q[0], hs_raw};
      vs_pipe_d = {vs_pipe_q[0], vs_raw};
      vid_de_d  = de_pipe_q[1];
      vid_hs_d  = hs_pipe_q[1];
      vid_vs_d  = vs_pipe_q[1];

      half_d = bus.rowram_rddata[0];
      colour = half_q ? bus.palram_rddata[55:32] : bus.palram_rddata[23:0];
      rgb_d  = (de_pipe_q[1] && frame_valid_q) ? colour : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q           <= '0;
         v_q           <= '0;
         de_pipe_q     <= '0;
         hs_pipe_q     <= '1;
         vs_pipe_q     <= '1;
         vid_de_q      <= 1'b0;
         vid_hs_q      <= 1'b1;
         vid_vs_q      <= 1'b1;
         half_q        <= 1'b0;
         frame_valid_q <= 1'b0;
         swap_q        <= 1'b0;
         next_row_q    <= '0;
         rgb_q         <= '0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         de_pipe_q     <= de_pipe_d;
         hs_pipe_q     <= hs_pipe_d;
         vs_pipe_q     <= vs_pipe_d;
         vid_de_q      <= vid_de_d;
         vid_hs_q      <= vid_hs_d;
         vid_vs_q      <= vid_vs_d;
         half_q        <= half_d;
         frame_valid_q <= frame_valid_d;
         swap_q        <= swap_d;
         next_row_q    <= next_row_d;
         rgb_q         <= rgb_d;
      end
   end

   assign bus.rowram_rdaddr = h_q[9:1];
   assign bus.palram_rdaddr = bus.rowram_rddata[9:1];
   assign bus.rowram_swap   = swap_q;
   assign bus.next_row      = next_row_q;
   assign bus.vid_r         = rgb_q[23:16];
   assign bus.vid_g         = rgb_q[15:8];
   assign bus.vid_b         = rgb_q[7:0];
   assign bus.vid_de        = vid_de_q;
   assign bus.vid_hsync     = vid_hs_q;
   assign bus.vid_vsync     = vid_vs_q;

   // Top byte of each palette entry carries no colour.
   assign unused_alpha = ^{bus.palram_rddata[63:56], bus.palram_rddata[31:24]};

endmodule

// File: tb/tb_ppu_scanout.sv
// Directed bench: a full-size instance for line-level checks and a shrunken-raster instance
// so whole-frame behaviour (swap schedule, frame_valid, palette path) fits in a short run.
module tb_ppu_scanout;

   localparam int SHVis = 16, SHFp = 2, SHSync = 4, SHBp = 2;
   localparam int SVVis = 12, SVFp = 2, SVSync = 2, SVBp = 3;
   localparam int SHTot = SHVis + SHFp + SHSync + SHBp;  // 24
   localparam int SVTot = SVVis + SVFp + SVSync + SVBp;  // 19
   localparam int SFrame = SHTot * SVTot;                // 456

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] ovr = 10'h203;
   int cyc;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   ppu_scanout_if bus_f ();
   ppu_scanout_if bus_s ();

   ppu_scanout u_full (
      .clk (clk),
      .rst (rst),
      .bus (bus_f.master)
   );

   ppu_scanout #(
      .H_VISIBLE (SHVis), .H_FP (SHFp), .H_SYNC (SHSync), .H_BP (SHBp),
      .V_VISIBLE (SVVis), .V_FP (SVFp), .V_SYNC (SVSync), .V_BP (SVBp)
   ) u_small (
      .clk (clk),
      .rst (rst),
      .bus (bus_s.master)
   );

   function automatic logic [9:0] row_word(input logic [8:0] a, input logic [9:0] o);
      return (a == 9'd5) ? o : {a, a[0]};
   endfunction

   function automatic logic [63:0] pal_word(input logic [8:0] p);
      if (p == 9'h101) return {32'h00AABBCC, 32'h00112233};
      return {8'hFF, p[7:0], 8'hC3, 8'h3C, 8'h99, p[7:0], 8'h5A, 8'hA5};
   endfunction

   function automatic logic [23:0] exp_colour(input logic [8:0] a, input logic [9:0] o);
      logic [9:0]  w;
      logic [63:0] pw;
      w  = row_word(a, o);
      pw = pal_word(w[9:1]);
      return w[0] ? pw[55:32] : pw[23:0];
   endfunction

   function automatic logic s_de(input int c);
      return ((c % SHTot) < SHVis) && (((c / SHTot) % SVTot) < SVVis);
   endfunction

   function automatic logic s_hs(input int c);
      int h;
      h = c % SHTot;
      return !((h >= SHVis + SHFp) && (h < SHVis + SHFp + SHSync));
   endfunction

   function automatic logic s_vs(input int c);
      int v;
      v = (c / SHTot) % SVTot;
      return !((v >= SVVis + SVFp) && (v < SVVis + SVFp + SVSync));
   endfunction

   // Row and palette RAMs: one-cycle registered reads.
   always @(posedge clk) begin
      bus_f.rowram_rddata <= row_word(bus_f.rowram_rdaddr, ovr);
      bus_f.palram_rddata <= pal_word(bus_f.palram_rdaddr);
      bus_s.rowram_rddata <= row_word(bus_s.rowram_rdaddr, ovr);
      bus_s.palram_rddata <= pal_word(bus_s.palram_rdaddr);
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic test_frame_valid();
      int c, de_cnt, hs_cnt, vs_cnt;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      wait_cyc(3);
      while (cyc < SFrame + 3) begin
         c = cyc - 3;
         n_cmp++;
         if (bus_s.vid_de !== s_de(c)) begin
            n_bad++; $display("FAIL de_f0 cyc=%0d got %b want %b", cyc, bus_s.vid_de, s_de(c));
         end
         n_cmp++;
         if (bus_s.vid_hsync !== s_hs(c)) begin
            n_bad++; $display("FAIL hs_f0 cyc=%0d got %b want %b", cyc, bus_s.vid_hsync, s_hs(c));
         end
         n_cmp++;
         if (bus_s.vid_vsync !== s_vs(c)) begin
            n_bad++; $display("FAIL vs_f0 cyc=%0d got %b want %b", cyc, bus_s.vid_vsync, s_vs(c));
         end
         n_cmp++;
         if ({bus_s.vid_r, bus_s.vid_g, bus_s.vid_b} !== 24'h0) begin
            n_bad++;
            $display("FAIL rgb_black_f0 cyc=%0d got %h want 000000", cyc,
                     {bus_s.vid_r, bus_s.vid_g, bus_s.vid_b});
         end
         de_cnt += int'(bus_s.vid_de === 1'b1);
         hs_cnt += int'(bus_s.vid_hsync === 1'b0);
         vs_cnt += int'(bus_s.vid_vsync === 1'b0);
         @(negedge clk);
      end
      n_cmp++;
      if (de_cnt != SHVis * SVVis) begin
         n_bad++; $display("FAIL de_count got %0d want %0d", de_cnt, SHVis * SVVis);
      end
      n_cmp++;
      if (hs_cnt != SHSync * SVTot) begin
         n_bad++; $display("FAIL hs_count got %0d want %0d", hs_cnt, SHSync * SVTot);
      end
      n_cmp++;
      if (vs_cnt != SVSync * SHTot) begin
         n_bad++; $display("FAIL vs_count got %0d want %0d", vs_cnt, SVSync * SHTot);
      end
   endtask

   task automatic test_reset();
      int k;
      wait_cyc(660);
      // Small raster: frame 1, v=8, h=9 at counter 657 -> visible game column 4.
      n_cmp++;
      if (bus_s.vid_de !== 1'b1) begin
         n_bad++; $display("FAIL pre_rst_de got %b want 1", bus_s.vid_de);
      end
      n_cmp++;
      if ({bus_s.vid_r, bus_s.vid_g, bus_s.vid_b} !== exp_colour(9'd4, ovr)) begin
         n_bad++;
         $display("FAIL pre_rst_rgb got %h want %h", {bus_s.vid_r, bus_s.vid_g, bus_s.vid_b},
                  exp_colour(9'd4, ovr));
      end
      n_cmp++;
      if (bus_s.next_row !== 8'd5) begin
         n_bad++; $display("FAIL pre_rst_next_row got %0d want 5", bus_s.next_row);
      end
      n_cmp++;
      if (bus_f.vid_hsync !== 1'b0) begin
         n_bad++; $display("FAIL pre_rst_hsync got %b want 0", bus_f.vid_hsync);
      end
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus_f.vid_r, bus_f.vid_g, bus_f.vid_b, bus_f.vid_de, bus_f.vid_hsync, bus_f.vid_vsync,
           bus_f.rowram_swap, bus_f.next_row} !== {24'h0, 4'b0110, 8'h0}) begin
         n_bad++;
         $display("FAIL rst_full got rgb=%h de=%b hs=%b vs=%b sw=%b nr=%0d", {bus_f.vid_r,
                  bus_f.vid_g, bus_f.vid_b}, bus_f.vid_de, bus_f.vid_hsync, bus_f.vid_vsync,
                  bus_f.rowram_swap, bus_f.next_row);
      end
      n_cmp++;
      if ({bus_s.vid_r, bus_s.vid_g, bus_s.vid_b, bus_s.vid_de, bus_s.vid_hsync, bus_s.vid_vsync,
           bus_s.rowram_swap, bus_s.next_row} !== {24'h0, 4'b0110, 8'h0}) begin
         n_bad++;
         $display("FAIL rst_small got rgb=%h de=%b hs=%b vs=%b sw=%b nr=%0d", {bus_s.vid_r,
                  bus_s.vid_g, bus_s.vid_b}, bus_s.vid_de, bus_s.vid_hsync, bus_s.vid_vsync,
                  bus_s.rowram_swap, bus_s.next_row);
      end
      n_cmp++;
      if (bus_f.rowram_rdaddr !== 9'd0) begin
         n_bad++; $display("FAIL rst_rdaddr got %0d want 0", bus_f.rowram_rdaddr);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      while (k < 2000) begin
         @(negedge clk);
         k++;
         if (bus_f.vid_hsync === 1'b0) break;
      end
      n_cmp++;
      if (k != 659) begin
         n_bad++; $display("FAIL hsync_first_fall got %0d want 659", k);
      end
   endtask

   task automatic test_swap_schedule();
      int h, v, obs;
      logic es;
      logic [7:0] exp_nr;
      exp_nr = 8'd1;
      obs = 0;
      wait_cyc(2 * SFrame);
      while (cyc < 4 * SFrame) begin
         h  = cyc % SHTot;
         v  = (cyc / SHTot) % SVTot;
         es = (h == SHVis) && (((v % 2 == 1) && (v <= SVVis - 3)) || (v == SVTot - 2));
         if (es) exp_nr = (v == SVTot - 2) ? 8'd1 : (v == SVVis - 3) ? 8'd0 : 8'((v + 3) / 2);
         n_cmp++;
         if (bus_s.rowram_swap !== es) begin
            n_bad++; $display("FAIL swap_s cyc=%0d got %b want %b", cyc, bus_s.rowram_swap, es);
         end
         n_cmp++;
         if (bus_s.next_row !== exp_nr) begin
            n_bad++;
            $display("FAIL next_row_s cyc=%0d got %0d want %0d", cyc, bus_s.next_row, exp_nr);
         end
         n_cmp++;
         if (bus_f.rowram_swap !== (cyc == 1440)) begin
            n_bad++;
            $display("FAIL swap_f cyc=%0d got %b want %b", cyc, bus_f.rowram_swap, cyc == 1440);
         end
         n_cmp++;
         if (bus_f.next_row !== ((cyc >= 1440) ? 8'd2 : 8'd0)) begin
            n_bad++; $display("FAIL next_row_f cyc=%0d got %0d", cyc, bus_f.next_row);
         end
         obs += int'(bus_s.rowram_swap === 1'b1);
         @(negedge clk);
      end
      n_cmp++;
      if (obs != SVVis) begin
         n_bad++; $display("FAIL swap_count got %0d want %0d", obs, SVVis);
      end
   endtask

   task automatic test_pixel_path();
      int c, n_hi, n_lo;
      logic [9:0]  o;
      logic [23:0] exp_rgb, got;
      n_hi = 0; n_lo = 0;
      wait_cyc(4 * SFrame + 3);
      while (cyc < 6 * SFrame + 3) begin
         if (cyc == 5 * SFrame - 80) ovr = 10'h202;
         c       = cyc - 3;
         o       = (c >= 5 * SFrame) ? 10'h202 : 10'h203;
         exp_rgb = s_de(c) ? exp_colour(9'((c % SHTot) / 2), o) : 24'h0;
         got     = {bus_s.vid_r, bus_s.vid_g, bus_s.vid_b};
         n_cmp++;
         if (got !== exp_rgb) begin
            n_bad++; $display("FAIL rgb cyc=%0d got %h want %h", cyc, got, exp_rgb);
         end
         n_cmp++;
         if ({bus_s.vid_de, bus_s.vid_hsync, bus_s.vid_vsync} !== {s_de(c), s_hs(c), s_vs(c)}) begin
            n_bad++;
            $display("FAIL sync cyc=%0d got %b%b%b want %b%b%b", cyc, bus_s.vid_de,
                     bus_s.vid_hsync, bus_s.vid_vsync, s_de(c), s_hs(c), s_vs(c));
         end
         n_hi += int'(got === 24'hAABBCC);
         n_lo += int'(got === 24'h112233);
         @(negedge clk);
      end
      n_cmp++;
      if (n_hi != 2 * SVVis) begin
         n_bad++; $display("FAIL px_aabbcc_count got %0d want %0d", n_hi, 2 * SVVis);
      end
      n_cmp++;
      if (n_lo != 2 * SVVis) begin
         n_bad++; $display("FAIL px_112233_count got %0d want %0d", n_lo, 2 * SVVis);
      end
   endtask

   task automatic test_vertical_scaling();
      logic [8:0] line20 [640];
      wait_cyc(20 * 800);
      for (int h = 0; h < 640; h++) begin
         line20[h] = bus_f.rowram_rdaddr;
         n_cmp++;
         if (bus_f.rowram_rdaddr !== 9'(h / 2)) begin
            n_bad++; $display("FAIL rdaddr_v20 h=%0d got %0d want %0d", h, bus_f.rowram_rdaddr, h / 2);
         end
         @(negedge clk);
      end
      wait_cyc(21 * 800);
      for (int h = 0; h < 640; h++) begin
         n_cmp++;
         if (bus_f.rowram_rdaddr !== line20[h] || bus_f.rowram_rdaddr !== 9'(h / 2)) begin
            n_bad++;
            $display("FAIL rdaddr_v21 h=%0d got %0d want %0d", h, bus_f.rowram_rdaddr, h / 2);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_frame_valid();
      test_reset();
      test_swap_schedule();
      test_pixel_path();
      test_vertical_scaling();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ppu_scanout.md
Name: ppu_scanout

Overview:
- Reader/display end of the PPU row-RAM protocol.
- Generates 640x480@60 raster timing from the pixel clock and reads the front row buffer, scaling each 320x240 game pixel 2x in each direction.
- Resolves row pixels through the palette RAM into 24-bit RGB for the HDMI transmitter.
- Issues rowram_swap and next_row, which tell the PPU when to swap buffers and which row to render next.

Parameters:
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_VISIBLE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  pixel clock (25.175 MHz); the block's single clock.
- rst  in  1  asynchronous reset, active-high.
- rowram_rdaddr  out  9  game-pixel column (0-319) into the front row buffer.
- rowram_rddata  in  10  pixel word; valid 1 cycle after address.
- palram_rdaddr  out  9  palette RAM word address.
- palram_rddata  in  64  two 32-bit colour entries; valid 1 cycle after address.
- rowram_swap  out  1  one-cycle pulse: swap front/back row buffers.
- next_row  out  8  game row (0-239) the PPU renders into the back buffer after the swap.
- vid_r, vid_g, vid_b  out  8 each  pixel colour.
- vid_hsync  out  1  active-low horizontal sync.
- vid_vsync  out  1  active-low vertical sync.
- vid_de  out  1  data enable (visible region).

Behaviour:
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524, and wraps to 0.
  - Both counters reset to 0.
- Raw timing:
  - de_raw = (h<640 && v<480).
  - hs_raw is low for h in 656..751.
  - vs_raw is low for v in 490..491.
- Pipeline:
  - S0: rowram_rdaddr = h_cnt[9:1], combinational from the counters. During blanking it is a don't-care but held at h_cnt[9:1] mod 512.
  - S1: palram_rdaddr = rowram_rddata[9:1], combinational. Register rowram_rddata[0] as the half-select.
  - S2: colour = half-select ? palram_rddata[63:32] : palram_rddata[31:0]. R=[23:16], G=[15:8], B=[7:0]; bits [31:24] are ignored.
  - S3: all vid_* outputs are registered. de/hs/vs are delayed 3 registers so they align with the colour.
  - Total latency is 3 clk from counter to pins.
- Blanking: when the delayed de is 0, or frame_valid is 0, vid_r/g/b = 0.
- Swap schedule:
  - rowram_swap is a registered output, high for exactly 1 cycle, in the cycle where h_cnt==H_VISIBLE, on the lines below.
  - v odd and v<=477: next_row = (v+3)/2 for v<=475; next_row = 0 at v=477.
  - v=523: next_row = 1.
  - This gives 240 pulses per frame.
  - next_row updates in the same cycle as rowram_swap and holds until the next pulse.
- Read-hazard guarantee: no visible-pixel row-RAM read is issued in the 2 cycles following a swap. This follows because the swap occurs at h=640; the last visible read at h=639 completes before the buffers change.
- frame_valid:
  - Resets to 0 and sets on the v=523 swap pulse; it stays 1 until reset.
  - While it is 0, the colour output is black, but syncs and de run normally.
  - The first frame after reset therefore displays black.
- Reset values:
  - vid_r/g/b = 0, vid_de = 0, vid_hsync = 1, vid_vsync = 1.
  - rowram_swap = 0, next_row = 0.
  - All pipeline registers cleared.
- Reset mid-operation:
  - Asserting rst mid-operation clears everything immediately (asynchronous), with no pending swap pulse.
  - Release restarts at h=v=0 with frame_valid=0.
- No backpressure: the raster free-runs, and the RAM latencies are fixed at 1 cycle each.

Test Plan:
1. Reset: assert rst mid-line -> all outputs are at their reset values in the same cycle. After release, vid_hsync first falls 656+3 cycles later.
2. Line/frame timing: run 2 frames -> hsync low for 96 clk every 800 clk; vsync low for exactly 2 lines per 525; 640 de cycles per line for 480 lines.
3. Swap schedule: count pulses over one frame -> exactly 240. Observe at v=1 -> next_row=2; at v=475 -> 239; at v=477 -> 0; at v=523 -> 1. Each pulse coincides with h_cnt=640.
4. Pixel path: model rowram returning 10'h203 at addr 5 and palram word 0x101 = {32'h00AABBCC, 32'h00112233}; second frame -> pixels x=10,11 show R=AA G=BB B=CC, 3 cycles after h=10. With rowram_rddata 10'h202 instead -> 11/22/33.
5. Vertical scaling: lines v=20 and v=21 issue identical rowram_rdaddr sequences 0,0,1,1,...,319,319.
6. frame_valid: the first frame after reset has de toggling but RGB all 0; from the frame following the first v=523 swap, RGB follows the palette.
